// File: rtl/conv_y_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : conv_y_out_fifo
// Purpose  : Output buffer between the convolution core and its consumer.
//            Accepts accumulator results over a valid/ready handshake and
//            stores them in a first-word-fall-through FIFO. Presents them
//            downstream with a per-frame last marker. Lets the core keep
//            streaming while the consumer stalls, up to DEPTH results.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Compile-time option:
//   Y_SAT_EN - when defined, results are clamped to the signed OUT_WIDTH
//              range before storage. Memory and output width become
//              OUT_WIDTH, and sat_flag records any clamp. When undefined,
//              the full ACC_SIZE result is stored unchanged and sat_flag
//              is tied low.
// ----------------------------------------------------------------------------
// Parameters:
//   ACC_SIZE    - width of the incoming accumulator result
//   OUT_WIDTH   - output width when Y_SAT_EN is defined
//   DEPTH       - FIFO entries (power of two, >= 2)
//   NUM_OUTPUTS - results per frame
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-low reset
//   s_valid_y    in   core result valid
//   s_ready_y    out  FIFO can accept a result (registered state only)
//   s_data_in_y  in   signed core result [ACC_SIZE]
//   m_valid_y    out  head entry valid
//   m_ready_y    in   consumer accepts head
//   m_data_out_y out  signed head data [OW]
//   m_last_y     out  head is the last result of its frame
//   fifo_count   out  entries currently held [$clog2(DEPTH)+1]
//   sat_flag     out  sticky saturation indicator
// ============================================================================
module conv_y_out_fifo #(
  parameter int ACC_SIZE    = 21,
  parameter int OUT_WIDTH   = 16,
  parameter int DEPTH       = 8,
  parameter int NUM_OUTPUTS = 97,
`ifdef Y_SAT_EN
  localparam int OW         = OUT_WIDTH,
`else
  localparam int OW         = ACC_SIZE,
`endif
  localparam int AW         = $clog2(DEPTH),
  localparam int CNT_W      = AW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid_y,
  output logic                s_ready_y,
  input  logic [ACC_SIZE-1:0] s_data_in_y,
  output logic                m_valid_y,
  input  logic                m_ready_y,
  output logic [OW-1:0]       m_data_out_y,
  output logic                m_last_y,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                sat_flag
);

  // Frame counter width; guard against a one-result frame.
  localparam int                 FRAME_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [FRAME_W-1:0] LAST_IDX = FRAME_W'(NUM_OUTPUTS - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   PTR_ONE  = CNT_W'(1);
  localparam logic [FRAME_W-1:0] FRM_ONE  = FRAME_W'(1);

  // Pointers carry one extra bit above the index so full and empty differ.
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic [FRAME_W-1:0] out_cnt;
  logic [OW-1:0]      mem [DEPTH];
  logic [OW-1:0]      store_data;
  logic               push;
  logic               pop;

  // --------------------------------------------------------------------------
  // Status and handshake. Everything here depends only on registered
  // pointers, so s_ready_y has no path from m_ready_y: a pop on a full FIFO
  // frees its slot only from the next cycle on.
  // --------------------------------------------------------------------------
  assign fifo_count   = wr_ptr - rd_ptr;
  assign s_ready_y    = (fifo_count != FULL_CNT);
  assign m_valid_y    = (fifo_count != '0);
  assign push         = s_valid_y && s_ready_y;
  assign pop          = m_valid_y && m_ready_y;
  assign m_data_out_y = mem[rd_ptr[AW-1:0]];
  assign m_last_y     = m_valid_y && (out_cnt == LAST_IDX);

  // --------------------------------------------------------------------------
  // Optional saturation of the incoming result
  // --------------------------------------------------------------------------
`ifdef Y_SAT_EN
  // The value fits in OUT_WIDTH signed bits when all bits from the OUT_WIDTH
  // sign position upward agree. Otherwise the value clamps toward its sign.
  localparam int HDR_W = ACC_SIZE - OUT_WIDTH + 1;

  logic [HDR_W-1:0] hdr_bits;
  logic             clamp;
  logic             sat_q;

  assign hdr_bits = s_data_in_y[ACC_SIZE-1:OUT_WIDTH-1];
  assign clamp    = !((hdr_bits == '0) || (hdr_bits == '1));

  always_comb begin
    store_data = s_data_in_y[OW-1:0];
    if (clamp) begin
      if (s_data_in_y[ACC_SIZE-1]) begin
        store_data = {1'b1, {(OW-1){1'b0}}};
      end else begin
        store_data = {1'b0, {(OW-1){1'b1}}};
      end
    end
  end

  // Only clamps on accepted pushes count; a held-off value is not stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else if (push && clamp) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign store_data = s_data_in_y;
  assign sat_flag   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Storage. Memory has no reset: a reset discards entries through the
  // pointers only.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= store_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and frame position
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      out_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (out_cnt == LAST_IDX) begin
          out_cnt <= '0;
        end else begin
          out_cnt <= out_cnt + FRM_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire
